// File: rtl/heart_surprise_ctrl_pkg.sv
// Shared types and constants for the heart surprise bonus object.
package heart_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    BLINK    = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam int OBJ_W = 32;
  localparam int OBJ_H = 32;
  localparam int CNT_W = 10;

  function automatic logic [10:0] clamp11(input logic [10:0] v, input logic [10:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/heart_surprise_ctrl_window.sv
// Registered scan-position window: offsets from the object's top-left corner
// plus a raw (visibility-agnostic) inside flag, one cycle after the pixel.
module square_object_window
  import heart_pkg::*;
#(
  parameter int OBJECT_WIDTH_X  = OBJ_W,
  parameter int OBJECT_HEIGHT_Y = OBJ_H
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] i_pixelX,
  input  logic [10:0] i_pixelY,
  input  logic [10:0] i_topLeftX,
  input  logic [10:0] i_topLeftY,
  output logic [10:0] o_offsetX,
  output logic [10:0] o_offsetY,
  output logic        o_insideRaw
);

  logic [11:0] w_rightX;
  logic [11:0] w_bottomY;
  logic        w_inside;
  logic [10:0] r_offsetX;
  logic [10:0] r_offsetY;
  logic        r_insideRaw;

  // Exclusive right/bottom edges kept in 12 bits so a box near 2047 cannot wrap.
  assign w_rightX  = {1'b0, i_topLeftX} + 12'(OBJECT_WIDTH_X);
  assign w_bottomY = {1'b0, i_topLeftY} + 12'(OBJECT_HEIGHT_Y);
  assign w_inside  = (i_pixelX >= i_topLeftX) && ({1'b0, i_pixelX} < w_rightX) &&
                     (i_pixelY >= i_topLeftY) && ({1'b0, i_pixelY} < w_bottomY);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_offsetX   <= '0;
      r_offsetY   <= '0;
      r_insideRaw <= 1'b0;
    end else begin
      r_offsetX   <= i_pixelX - i_topLeftX;
      r_offsetY   <= i_pixelY - i_topLeftY;
      r_insideRaw <= w_inside;
    end
  end

  assign o_offsetX   = r_offsetX;
  assign o_offsetY   = r_offsetY;
  assign o_insideRaw = r_insideRaw;

endmodule

// File: rtl/heart_surprise_ctrl.sv
// Heart surprise lifecycle controller: spawn, timed lifetime with pre-expiry
// blink, collection, cooldown; drives the heart bitmap stage's window inputs.
module heart_surprise_ctrl
  import heart_pkg::*;
#(
  parameter int OBJECT_WIDTH_X    = OBJ_W,
  parameter int OBJECT_HEIGHT_Y   = OBJ_H,
  parameter int SCREEN_W          = 640,
  parameter int SCREEN_H          = 480,
  parameter int LIFETIME_FRAMES   = 600,
  parameter int BLINK_FRAMES      = 120,
  parameter int BLINK_HALF_PERIOD = 8,
  parameter int COOLDOWN_FRAMES   = 60
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        spawnReq,
  input  logic [10:0] spawnX,
  input  logic [10:0] spawnY,
  input  logic        collision,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic        heartActive,
  output logic        collectedPulse,
  output logic        expiredPulse
);

  localparam logic [10:0]      MAX_X      = 11'(SCREEN_W - OBJECT_WIDTH_X);
  localparam logic [10:0]      MAX_Y      = 11'(SCREEN_H - OBJECT_HEIGHT_Y);
  localparam logic [CNT_W-1:0] LIFE_INIT  = CNT_W'(LIFETIME_FRAMES);
  localparam logic [CNT_W-1:0] BLINK_AT   = CNT_W'(BLINK_FRAMES);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(BLINK_HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] COOL_INIT  = CNT_W'(COOLDOWN_FRAMES);

  state_t           r_state, w_stateNext;
  logic [10:0]      r_topLeftX, w_topLeftXNext;
  logic [10:0]      r_topLeftY, w_topLeftYNext;
  logic [CNT_W-1:0] r_lifeCnt, w_lifeCntNext, w_lifeDec;
  logic [CNT_W-1:0] r_blinkCnt, w_blinkCntNext;
  logic [CNT_W-1:0] r_coolCnt, w_coolCntNext;
  logic             r_phaseVis, w_phaseVisNext;
  logic             w_collect, w_expire;
  logic             r_heartActive, r_collected, r_expired, r_visible;
  logic             w_insideRaw;

  square_object_window #(
    .OBJECT_WIDTH_X (OBJECT_WIDTH_X),
    .OBJECT_HEIGHT_Y(OBJECT_HEIGHT_Y)
  ) u_window (
    .clk        (clk),
    .resetN     (resetN),
    .i_pixelX   (pixelX),
    .i_pixelY   (pixelY),
    .i_topLeftX (r_topLeftX),
    .i_topLeftY (r_topLeftY),
    .o_offsetX  (offsetX),
    .o_offsetY  (offsetY),
    .o_insideRaw(w_insideRaw)
  );

  assign w_lifeDec = r_lifeCnt - CNT_W'(1);

  always_comb begin
    w_stateNext    = r_state;
    w_topLeftXNext = r_topLeftX;
    w_topLeftYNext = r_topLeftY;
    w_lifeCntNext  = r_lifeCnt;
    w_blinkCntNext = r_blinkCnt;
    w_coolCntNext  = r_coolCnt;
    w_phaseVisNext = r_phaseVis;
    w_collect      = 1'b0;
    w_expire       = 1'b0;
    case (r_state)
      IDLE: begin
        if (spawnReq) begin
          w_stateNext    = ACTIVE;
          w_topLeftXNext = clamp11(spawnX, MAX_X);
          w_topLeftYNext = clamp11(spawnY, MAX_Y);
          w_lifeCntNext  = LIFE_INIT;
        end
      end
      ACTIVE, BLINK: begin
        // Collision is checked first so it beats a simultaneous lifetime end.
        if (collision) begin
          w_stateNext   = COOLDOWN;
          w_coolCntNext = COOL_INIT;
          w_collect     = 1'b1;
        end else if (startOfFrame) begin
          w_lifeCntNext = w_lifeDec;
          if (w_lifeDec == '0) begin
            w_stateNext   = COOLDOWN;
            w_coolCntNext = COOL_INIT;
            w_expire      = 1'b1;
          end else if (r_state == ACTIVE) begin
            if (w_lifeDec == BLINK_AT) begin
              w_stateNext    = BLINK;
              w_blinkCntNext = '0;
              w_phaseVisNext = 1'b1;
            end
          end else if (r_blinkCnt == HALF_LAST) begin
            w_blinkCntNext = '0;
            w_phaseVisNext = ~r_phaseVis;
          end else begin
            w_blinkCntNext = r_blinkCnt + CNT_W'(1);
          end
        end
      end
      COOLDOWN: begin
        if (startOfFrame) begin
          if (r_coolCnt <= CNT_W'(1)) begin
            w_stateNext   = IDLE;
            w_coolCntNext = '0;
          end else begin
            w_coolCntNext = r_coolCnt - CNT_W'(1);
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= IDLE;
      r_topLeftX    <= '0;
      r_topLeftY    <= '0;
      r_lifeCnt     <= '0;
      r_blinkCnt    <= '0;
      r_coolCnt     <= '0;
      r_phaseVis    <= 1'b0;
      r_heartActive <= 1'b0;
      r_collected   <= 1'b0;
      r_expired     <= 1'b0;
      r_visible     <= 1'b0;
    end else begin
      r_state       <= w_stateNext;
      r_topLeftX    <= w_topLeftXNext;
      r_topLeftY    <= w_topLeftYNext;
      r_lifeCnt     <= w_lifeCntNext;
      r_blinkCnt    <= w_blinkCntNext;
      r_coolCnt     <= w_coolCntNext;
      r_phaseVis    <= w_phaseVisNext;
      r_heartActive <= (w_stateNext == ACTIVE) || (w_stateNext == BLINK);
      r_collected   <= w_collect;
      r_expired     <= w_expire;
      // Sampled on the same edge as the raw window flag so both describe one pixel.
      r_visible     <= (r_state == ACTIVE) || ((r_state == BLINK) && r_phaseVis);
    end
  end

  assign InsideRectangle = w_insideRaw & r_visible;
  assign heartActive     = r_heartActive;
  assign collectedPulse  = r_collected;
  assign expiredPulse    = r_expired;

endmodule

// File: tb/tb_heart_surprise_ctrl.sv
// Self-checking bench for heart_surprise_ctrl: window vectors, lifecycle timing,
// collision priority and ignored requests.
module tb_heart_surprise_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX, pixelY;
  logic        spawnReq;
  logic [10:0] spawnX, spawnY;
  logic        collision;
  logic [10:0] offsetX, offsetY;
  logic        InsideRectangle, heartActive, collectedPulse, expiredPulse;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic        ins;
    logic [10:0] ox;
    logic [10:0] oy;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[6];

  heart_surprise_ctrl dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .spawnReq       (spawnReq),
    .spawnX         (spawnX),
    .spawnY         (spawnY),
    .collision      (collision),
    .offsetX        (offsetX),
    .offsetY        (offsetY),
    .InsideRectangle(InsideRectangle),
    .heartActive    (heartActive),
    .collectedPulse (collectedPulse),
    .expiredPulse   (expiredPulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask

  task automatic spawn(input logic [10:0] x, input logic [10:0] y);
    spawnReq = 1'b1;
    spawnX   = x;
    spawnY   = y;
    tick();
    spawnReq = 1'b0;
  endtask

  // Drive one pixel, queue its expectation, compare when the registered result appears.
  task automatic probe(input string name, input logic [10:0] x, input logic [10:0] y,
                       input logic ins, input logic [10:0] ox, input logic [10:0] oy);
    vec_t v;
    vec_t got;
    v.x = x; v.y = y; v.ins = ins; v.ox = ox; v.oy = oy;
    pixelX = x;
    pixelY = y;
    exp_q.push_back(v);
    tick();
    got = exp_q.pop_front();
    chk({name, "_inside"}, 32'(InsideRectangle), 32'(got.ins));
    chk({name, "_offX"}, 32'(offsetX), 32'(got.ox));
    chk({name, "_offY"}, 32'(offsetY), 32'(got.oy));
  endtask

  initial begin
    int errs;
    logic exp_vis;

    resetN = 1'b0; startOfFrame = 1'b0; spawnReq = 1'b0; collision = 1'b0;
    pixelX = '0; pixelY = '0; spawnX = '0; spawnY = '0;

    tbl[0] = '{11'd100, 11'd50, 1'b1, 11'd0,    11'd0};
    tbl[1] = '{11'd131, 11'd81, 1'b1, 11'd31,   11'd31};
    tbl[2] = '{11'd132, 11'd50, 1'b0, 11'd32,   11'd0};
    tbl[3] = '{11'd99,  11'd50, 1'b0, 11'd2047, 11'd0};
    tbl[4] = '{11'd100, 11'd82, 1'b0, 11'd0,    11'd32};
    tbl[5] = '{11'd115, 11'd60, 1'b1, 11'd15,   11'd10};

    // Reset state
    repeat (2) tick();
    chk("rst_offX", 32'(offsetX), 0);
    chk("rst_offY", 32'(offsetY), 0);
    chk("rst_inside", 32'(InsideRectangle), 0);
    chk("rst_active", 32'(heartActive), 0);
    chk("rst_collected", 32'(collectedPulse), 0);
    chk("rst_expired", 32'(expiredPulse), 0);
    resetN = 1'b1;
    tick();

    // Basic spawn and window table
    spawn(11'd100, 11'd50);
    chk("spawn_active", 32'(heartActive), 1);
    for (int i = 0; i < 6; i++)
      probe($sformatf("win%0d", i), tbl[i].x, tbl[i].y, tbl[i].ins, tbl[i].ox, tbl[i].oy);

    // Asynchronous reset while ACTIVE, pixel inside
    pixelX = 11'd110; pixelY = 11'd60;
    tick();
    chk("pre_rst_inside", 32'(InsideRectangle), 1);
    resetN = 1'b0;
    #1;
    chk("async_rst_active", 32'(heartActive), 0);
    chk("async_rst_inside", 32'(InsideRectangle), 0);
    chk("async_rst_offX", 32'(offsetX), 0);
    tick();
    resetN = 1'b1;
    tick();

    // Collision in IDLE is ignored
    collision = 1'b1;
    tick();
    collision = 1'b0;
    chk("idle_coll_pulse", 32'(collectedPulse), 0);
    chk("idle_coll_active", 32'(heartActive), 0);

    // Clamped spawn
    spawn(11'd630, 11'd470);
    chk("clamp_active", 32'(heartActive), 1);
    probe("clamp_tl", 11'd608, 11'd448, 1'b1, 11'd0, 11'd0);
    probe("clamp_br", 11'd639, 11'd479, 1'b1, 11'd31, 11'd31);
    probe("clamp_left", 11'd607, 11'd448, 1'b0, 11'd2047, 11'd0);
    probe("clamp_below", 11'd608, 11'd480, 1'b0, 11'd0, 11'd32);

    // Lifetime: five frames, an ignored spawn, then the rest
    for (int k = 1; k <= 5; k++) sof();
    spawn(11'd200, 11'd200);
    chk("active_spawn_kept", 32'(heartActive), 1);
    probe("frozen_pos", 11'd608, 11'd448, 1'b1, 11'd0, 11'd0);
    probe("frozen_other", 11'd200, 11'd200, 1'b0, 11'd1640, 11'd1800);
    pixelX = 11'd608; pixelY = 11'd448;
    tick();

    errs = 0;
    for (int k = 6; k <= 600; k++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      if (k == 600) begin
        chk("expire_pulse", 32'(expiredPulse), 1);
        chk("expire_no_collect", 32'(collectedPulse), 0);
        chk("expire_inactive", 32'(heartActive), 0);
      end else if (expiredPulse !== 1'b0 || heartActive !== 1'b1) begin
        errs++;
      end
      tick();
      if (k < 480)      exp_vis = 1'b1;
      else if (k < 600) exp_vis = (((k - 480) / 8) % 2) == 0;
      else              exp_vis = 1'b0;
      if (k == 487) chk("blink_last_visible", 32'(InsideRectangle), 1);
      if (k == 488) chk("blink_first_hidden", 32'(InsideRectangle), 0);
      if (k == 496) chk("blink_visible_again", 32'(InsideRectangle), 1);
      if (k == 600) chk("expire_single_cycle", 32'(expiredPulse), 0);
      if (InsideRectangle !== exp_vis) errs++;
    end
    chk("lifetime_sequence_errs", 32'(errs), 0);

    // Cooldown: 60 frames, requests and collisions ignored
    errs = 0;
    for (int c = 1; c <= 59; c++) begin
      sof();
      if (heartActive !== 1'b0) errs++;
      if (c == 30) begin
        spawn(11'd100, 11'd50);
        chk("cool_spawn_ignored", 32'(heartActive), 0);
        collision = 1'b1;
        tick();
        collision = 1'b0;
        chk("cool_coll_ignored", 32'(collectedPulse), 0);
      end
    end
    chk("cool_inactive_errs", 32'(errs), 0);
    spawn(11'd100, 11'd50);
    chk("cool_len_59", 32'(heartActive), 0);
    sof();
    spawn(11'd100, 11'd50);
    chk("cool_done_spawn", 32'(heartActive), 1);
    probe("respawn_pos", 11'd100, 11'd50, 1'b1, 11'd0, 11'd0);

    // Collision coinciding with final lifetime decrement
    for (int k = 1; k <= 599; k++) sof();
    chk("final_frame_active", 32'(heartActive), 1);
    startOfFrame = 1'b1;
    collision    = 1'b1;
    tick();
    startOfFrame = 1'b0;
    collision    = 1'b0;
    chk("tie_collected", 32'(collectedPulse), 1);
    chk("tie_no_expire", 32'(expiredPulse), 0);
    chk("tie_inactive", 32'(heartActive), 0);
    tick();
    chk("tie_pulse_single", 32'(collectedPulse), 0);
    spawn(11'd100, 11'd50);
    chk("tie_cool_spawn_ignored", 32'(heartActive), 0);
    probe("tie_hidden", 11'd100, 11'd50, 1'b0, 11'd0, 11'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
